write_back_buffer: RTL and testbench

WRITE_BACK_BUFFER -- requirements
Module: write_back_buffer

---
 rtl/write_back_buffer.sv | 161 ++++++++++++++++
 tb/tb_write_back_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_buffer.sv
// Write-back buffer: small circular FIFO of evicted dirty lines drained to memory.
// Ports: clk/reset; evict push (evict_address, evict_data); lookup probe
// (lookup_address -> lookup_hit, lookup_data); memory write port
// (mem_write, mem_address, mem_data, mem_ack); status (full, empty, count, overflow).
module write_back_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     evict,
  input  logic [ADDR_W-1:0]        evict_address,
  input  logic [DATA_W-1:0]        evict_data,
  input  logic [ADDR_W-1:0]        lookup_address,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_ack,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [DEPTH-1:0]    valid_q;
  logic [PW-1:0]       head_q;
  logic [PW-1:0]       tail_q;
  logic [CW-1:0]       count_q;

  logic [PW-1:0]       slot [DEPTH];
  logic                coal_hit;
  logic [PW-1:0]       coal_idx;
  logic                coalesce;
  logic                pop;
  logic                push_new;
  logic                drop;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign pop      = (state_q == ISSUE) && mem_ack;
  assign coalesce = evict && coal_hit;
  assign push_new = evict && !coal_hit && (!full || pop);
  assign drop     = evict && !coal_hit && full && !pop;

  // slot[k] is the k-th oldest position, so later matches are younger
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot[k] = head_q + PW'(k);
    end
  end

  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[slot[k]] && addr_q[slot[k]] == lookup_address) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[slot[k]];
      end
    end
  end

  // The in-flight head has its data latched already, so it is never
  // a coalesce target; a matching push then allocates a fresh entry.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[slot[k]] && addr_q[slot[k]] == evict_address &&
          !(state_q == ISSUE && k == 0)) begin
        coal_hit = 1'b1;
        coal_idx = slot[k];
      end
    end
  end

  // When full, tail equals head; the push write must win over the pop clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (pop)      valid_q[head_q] <= 1'b0;
      if (push_new) valid_q[tail_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (coalesce) data_q[coal_idx] <= evict_data;
      if (push_new) begin
        addr_q[tail_q] <= evict_address;
        data_q[tail_q] <= evict_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop)      head_q <= head_q + 1'b1;
      if (push_new) tail_q <= tail_q + 1'b1;
      case ({push_new, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      overflow    <= 1'b0;
    end else begin
      overflow <= drop;
      case (state_q)
        IDLE: begin
          mem_write <= 1'b0;
          if (!empty) begin
            state_q     <= ISSUE;
            mem_write   <= 1'b1;
            mem_address <= addr_q[head_q];
            // forward a same-cycle coalesce into the head being launched
            mem_data    <= (coalesce && coal_idx == head_q) ?
                           evict_data : data_q[head_q];
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_back_buffer.sv
// Testbench for write_back_buffer: directed pushes, scoreboard of expected
// memory writes checked by an independent monitor, plus status/lookup checks.
module tb_write_back_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          evict;
  logic [AW-1:0] evict_address;
  logic [DW-1:0] evict_data;
  logic [AW-1:0] lookup_address;
  logic          lookup_hit;
  logic [DW-1:0] lookup_data;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_ack;
  logic          full;
  logic          empty;
  logic [2:0]    count;
  logic          overflow;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  ack_delay = 0;
  bit  ack_en = 1'b0;
  bit  ack_force = 1'b0;

  write_back_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .evict(evict), .evict_address(evict_address), .evict_data(evict_data),
    .lookup_address(lookup_address), .lookup_hit(lookup_hit),
    .lookup_data(lookup_data),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
    .mem_ack(mem_ack),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    evict         = 1'b1;
    evict_address = a;
    evict_data    = d;
    tick();
    evict = 1'b0;
  endtask

  task automatic look(input string nm, input logic [AW-1:0] a,
                      input logic hit, input logic [DW-1:0] d);
    lookup_address = a;
    #1;
    chk({nm, "_hit"}, 64'(lookup_hit), 64'(hit));
    chk({nm, "_data"}, 64'(lookup_data), 64'(d));
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 100; i++) begin
      if (empty && !mem_write) break;
      tick();
    end
    chk({nm, "_drained"}, 64'(empty && !mem_write), 64'd1);
    chk({nm, "_count0"}, 64'(count), 64'd0);
    chk({nm, "_sb_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // memory responder: acks after ack_delay cycles of mem_write, or on force
  initial begin
    int hold;
    hold    = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_write) begin
        mem_ack = ack_force || (ack_en && hold >= ack_delay);
        hold++;
      end else begin
        mem_ack = ack_force;
        hold    = 0;
      end
    end
  end

  // monitor: every presented write must match the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && mem_write) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mem_unexpected: got %0h/%0h expected none",
                   mem_address, mem_data);
        end else begin
          chk("mem_address", 64'(mem_address), 64'(exp_q[0].a));
          chk("mem_data", 64'(mem_data), 64'(exp_q[0].d));
          if (mem_ack) exp_q.delete(0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    evict          = 1'b0;
    evict_address  = '0;
    evict_data     = '0;
    lookup_address = 32'h100;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_mem_address", 64'(mem_address), 64'd0);
    chk("rst_mem_data", 64'(mem_data), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    look("rst_look", 32'h100, 1'b0, 32'h0);

    // single push, ack two cycles after mem_write rises
    ack_en    = 1'b1;
    ack_delay = 2;
    expect_wr(32'h100, 32'hAAAAAAAA);
    push(32'h100, 32'hAAAAAAAA);
    chk("a_count1", 64'(count), 64'd1);
    look("a_look", 32'h100, 1'b1, 32'hAAAAAAAA);
    tick();
    chk("a_mem_write", 64'(mem_write), 64'd1);
    tick();
    tick();
    chk("a_still_held", 64'(mem_write), 64'd1);
    drain("a");

    // fill, overflow, drain in order
    ack_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect_wr(32'(i * 16), 32'(32'h1000 + i * 16));
      push(32'(i * 16), 32'(32'h1000 + i * 16));
    end
    chk("b_full", 64'(full), 64'd1);
    chk("b_count4", 64'(count), 64'd4);
    push(32'h50, 32'h1050);
    chk("b_overflow", 64'(overflow), 64'd1);
    chk("b_count_ovf", 64'(count), 64'd4);
    tick();
    chk("b_overflow_pulse", 64'(overflow), 64'd0);
    look("b_look50", 32'h50, 1'b0, 32'h0);
    look("b_look30", 32'h30, 1'b1, 32'h1030);
    ack_en    = 1'b1;
    ack_delay = 0;
    drain("b");

    // coalesce into a non-head entry
    ack_en = 1'b0;
    expect_wr(32'h20, 32'h1111);
    expect_wr(32'h30, 32'h2222);
    push(32'h20, 32'h1111);
    push(32'h30, 32'h3333);
    chk("c_issue", 64'(mem_write), 64'd1);
    push(32'h30, 32'h2222);
    chk("c_count2", 64'(count), 64'd2);
    look("c_look30", 32'h30, 1'b1, 32'h2222);
    ack_en    = 1'b1;
    ack_delay = 1;
    drain("c");

    // push matching the in-flight head allocates a new entry
    ack_en = 1'b0;
    expect_wr(32'h20, 32'h1111);
    expect_wr(32'h20, 32'h5555);
    push(32'h20, 32'h1111);
    tick();
    chk("d_issue", 64'(mem_write), 64'd1);
    push(32'h20, 32'h5555);
    chk("d_count2", 64'(count), 64'd2);
    look("d_look20", 32'h20, 1'b1, 32'h5555);
    chk("d_head_data", 64'(mem_data), 64'h1111);
    ack_en    = 1'b1;
    ack_delay = 1;
    drain("d");

    // full buffer, push in the same cycle as the ack
    ack_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect_wr(32'(i * 16), 32'(32'hE000 + i * 16));
      push(32'(i * 16), 32'(32'hE000 + i * 16));
    end
    expect_wr(32'h60, 32'hE060);
    chk("e_full", 64'(full), 64'd1);
    ack_force = 1'b1;
    push(32'h60, 32'hE060);
    ack_force = 1'b0;
    chk("e_no_overflow", 64'(overflow), 64'd0);
    chk("e_count4", 64'(count), 64'd4);
    chk("e_full_after", 64'(full), 64'd1);
    look("e_look10", 32'h10, 1'b0, 32'h0);
    look("e_look60", 32'h60, 1'b1, 32'hE060);
    ack_en    = 1'b1;
    ack_delay = 0;
    drain("e");

    // reset during ISSUE abandons everything, ack in reset cycle ignored
    ack_en = 1'b0;
    expect_wr(32'h70, 32'h7777);
    push(32'h70, 32'h7777);
    push(32'h80, 32'h8888);
    push(32'h90, 32'h9999);
    chk("f_issue", 64'(mem_write), 64'd1);
    chk("f_count3", 64'(count), 64'd3);
    reset     = 1'b1;
    ack_force = 1'b1;
    exp_q.delete();
    tick();
    reset     = 1'b0;
    ack_force = 1'b0;
    chk("f_mem_write", 64'(mem_write), 64'd0);
    chk("f_count0", 64'(count), 64'd0);
    chk("f_empty", 64'(empty), 64'd1);
    look("f_look70", 32'h70, 1'b0, 32'h0);
    look("f_look80", 32'h80, 1'b0, 32'h0);
    look("f_look90", 32'h90, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    chk("f_idle_after", 64'(mem_write), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
